// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Also holds the small decode helpers used by the top level.
package seg_display_arbiter_pkg;

    typedef enum logic {
        StIdle,
        StShow
    } arb_state_e;

    localparam logic [1:0] OWNER_IDLE = 2'd3;
    localparam logic [1:0] REQ_RX     = 2'd0;
    localparam logic [1:0] REQ_TX     = 2'd1;
    localparam logic [1:0] REQ_ERR    = 2'd2;

    localparam int unsigned NUM_DIGITS = 4;

    // Fixed priority: the error requester wins, RX loses.
    function automatic logic [1:0] highest_req(input logic [2:0] r);
        if (r[REQ_ERR]) begin
            return REQ_ERR;
        end else if (r[REQ_TX]) begin
            return REQ_TX;
        end
        return REQ_RX;
    endfunction

    function automatic logic [3:0] digit_anodes(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] select_nibble(input logic [15:0] word, input logic [1:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_display_arbiter_digit_scanner.sv
// Free-running digit multiplex scan: a refresh prescaler that steps the
// active digit index each time it wraps.
module digit_scanner
    import seg_display_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] digit_idx
);

    localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CYCLES - 1);
    localparam logic [1:0] LastDigit = 2'(NUM_DIGITS - 1);

    logic [CntW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]      digit_idx_q, digit_idx_d;

    always_comb begin
        refresh_cnt_d = refresh_cnt_q;
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == CntLast) begin
            refresh_cnt_d = '0;
            digit_idx_d   = (digit_idx_q == LastDigit) ? 2'd0 : digit_idx_q + 2'd1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    assign digit_idx = digit_idx_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority arbiter sharing one 4-digit 7-segment display between
// RX, TX and error requesters, with minimum hold time and idle fallback.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 200_000,
    parameter int unsigned HOLD_CYCLES    = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    input  logic [15:0] idle_msg,
    output logic [2:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [3:0]  an,
    output logic [3:0]  digit_code
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [15:0]      msg_q, msg_d;

    logic       grant;
    logic [1:0] grant_idx;
    logic       hold_done;
    logic [1:0] digit_idx;
    logic [15:0] disp_word;

    digit_scanner #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_scanner (
        .clk      (clk),
        .reset    (reset),
        .digit_idx(digit_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        msg_d     = msg_q;
        grant     = 1'b0;
        grant_idx = highest_req(req);
        hold_done = (hold_q == HoldLast);

        case (state_q)
            StIdle: begin
                grant = |req;
            end
            StShow: begin
                // At expiry any waiting request takes over with no idle gap.
                if (|req && (grant_idx >= owner_q || hold_done)) begin
                    grant = 1'b1;
                end else if (hold_done) begin
                    state_d = StIdle;
                    owner_d = OWNER_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OWNER_IDLE;
                hold_d  = '0;
            end
        endcase

        if (grant) begin
            state_d = StShow;
            owner_d = grant_idx;
            hold_d  = '0;
            msg_d   = req_data[{grant_idx, 4'b0000} +: 16];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OWNER_IDLE;
            hold_q  <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            msg_q   <= msg_d;
        end
    end

    // Gated so a request held through reset is never acknowledged.
    assign ack        = (grant && !reset) ? (3'b001 << grant_idx) : 3'b000;
    assign owner      = owner_q;
    assign busy       = (state_q == StShow);
    assign disp_word  = (state_q == StShow) ? msg_q : idle_msg;
    assign an         = digit_anodes(digit_idx);
    assign digit_code = select_nibble(disp_word, digit_idx);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with REFRESH_CYCLES=4, HOLD_CYCLES=10.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] req_data;
    logic [15:0] idle_msg;
    logic [2:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  an;
    logic [3:0]  digit_code;

    int total = 0;
    int bad = 0;
    int scan_cyc = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] idle_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    seg_display_arbiter #(
        .REFRESH_CYCLES(4),
        .HOLD_CYCLES   (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .idle_msg  (idle_msg),
        .ack       (ack),
        .owner     (owner),
        .busy      (busy),
        .an        (an),
        .digit_code(digit_code)
    );

    always #5 clk = ~clk;

    // Reference scan position: clock edges since reset released.
    always @(posedge clk or posedge reset) begin
        if (reset) scan_cyc <= 0;
        else       scan_cyc <= scan_cyc + 1;
    end

    function automatic logic [3:0] exp_code(input logic [15:0] w);
        int d;
        d = (scan_cyc / 4) % 4;
        return w[d*4 +: 4];
    endfunction

    function automatic logic [3:0] exp_an();
        int d;
        logic [3:0] a;
        d = (scan_cyc / 4) % 4;
        a = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req = 3'b000;
        req_data = '0;
        idle_msg = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an: got %b want 1110", an); end
        total++; if (digit_code !== 4'h4) begin bad++; $display("FAIL reset_code: got %h want 4", digit_code); end
        total++; if (owner !== 2'd3) begin bad++; $display("FAIL reset_owner: got %0d want 3", owner); end
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack: got %b want 000", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++; if (an !== an_tab[(i/4)%4]) begin bad++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, an_tab[(i/4)%4]); end
            total++; if (digit_code !== idle_tab[(i/4)%4]) begin bad++; $display("FAIL scan_code[%0d]: got %h want %h", i, digit_code, idle_tab[(i/4)%4]); end
            total++; if (owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL scan_idle[%0d]: got owner=%0d busy=%b want 3/0", i, owner, busy); end
        end
    endtask

    task automatic test_rx();
        @(posedge clk); #1 req = 3'b001; req_data = {32'h0, 16'hABCD};
        @(negedge clk);
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL rx_ack: got %b want 001", ack); end
        total++; if (owner !== 2'd3) begin bad++; $display("FAIL rx_owner_pre: got %0d want 3", owner); end
        @(posedge clk); #1 req = 3'b000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1 || owner !== 2'd0) begin bad++; $display("FAIL rx_show[%0d]: got busy=%b owner=%0d want 1/0", k, busy, owner); end
            total++; if (ack !== 3'b000) begin bad++; $display("FAIL rx_ack_once[%0d]: got %b want 000", k, ack); end
            total++; if (digit_code !== exp_code(16'hABCD)) begin bad++; $display("FAIL rx_code[%0d]: got %h want %h", k, digit_code, exp_code(16'hABCD)); end
            total++; if (an !== exp_an()) begin bad++; $display("FAIL rx_an[%0d]: got %b want %b", k, an, exp_an()); end
        end
        @(negedge clk);
        total++; if (owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL rx_expire: got owner=%0d busy=%b want 3/0", owner, busy); end
        total++; if (digit_code !== exp_code(16'h1234)) begin bad++; $display("FAIL rx_idle_code: got %h want %h", digit_code, exp_code(16'h1234)); end
    endtask

    task automatic test_priority();
        @(posedge clk); #1 req = 3'b101; req_data = {16'hEEEE, 16'h0000, 16'h1111};
        @(negedge clk);
        total++; if (ack !== 3'b100) begin bad++; $display("FAIL prio_ack: got %b want 100", ack); end
        @(posedge clk); #1 req = 3'b001;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++; if (owner !== 2'd2 || ack !== 3'b000) begin bad++; $display("FAIL prio_hold[%0d]: got owner=%0d ack=%b want 2/000", k, owner, ack); end
            total++; if (digit_code !== exp_code(16'hEEEE)) begin bad++; $display("FAIL prio_code[%0d]: got %h want %h", k, digit_code, exp_code(16'hEEEE)); end
        end
        @(negedge clk);
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL prio_expire_ack: got %b want 001", ack); end
        @(posedge clk); #1 req = 3'b000;
        @(negedge clk);
        total++; if (owner !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL prio_handoff: got owner=%0d busy=%b want 0/1", owner, busy); end
        total++; if (digit_code !== exp_code(16'h1111)) begin bad++; $display("FAIL prio_handoff_code: got %h want %h", digit_code, exp_code(16'h1111)); end
        repeat (10) @(negedge clk);
        total++; if (owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL prio_drain: got owner=%0d busy=%b want 3/0", owner, busy); end
    endtask

    task automatic test_preempt();
        @(posedge clk); #1 req = 3'b001; req_data = {32'h0, 16'h1111};
        @(negedge clk);
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL pre_ack0: got %b want 001", ack); end
        @(posedge clk); #1 req = 3'b000;
        repeat (5) @(posedge clk);
        #1 req = 3'b010; req_data = {16'h0, 16'h2222, 16'h1111};
        @(negedge clk);
        total++; if (ack !== 3'b010) begin bad++; $display("FAIL pre_ack1: got %b want 010", ack); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL pre_owner_old: got %0d want 0", owner); end
        @(posedge clk); #1 req = 3'b000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (owner !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL pre_show[%0d]: got owner=%0d busy=%b want 1/1", k, owner, busy); end
            total++; if (digit_code !== exp_code(16'h2222)) begin bad++; $display("FAIL pre_code[%0d]: got %h want %h", k, digit_code, exp_code(16'h2222)); end
        end
        @(negedge clk);
        total++; if (owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL pre_expire: got owner=%0d busy=%b want 3/0", owner, busy); end
    endtask

    task automatic test_wait();
        @(posedge clk); #1 req = 3'b100; req_data = {16'hEEEE, 32'h0};
        @(negedge clk);
        total++; if (ack !== 3'b100) begin bad++; $display("FAIL wait_ack2: got %b want 100", ack); end
        @(posedge clk); #1 req = 3'b010; req_data = {16'hEEEE, 16'h2222, 16'h0};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++; if (ack !== 3'b000 || owner !== 2'd2) begin bad++; $display("FAIL wait_hold[%0d]: got ack=%b owner=%0d want 000/2", k, ack, owner); end
        end
        @(negedge clk);
        total++; if (ack !== 3'b010) begin bad++; $display("FAIL wait_ack1: got %b want 010", ack); end
        @(posedge clk); #1 req = 3'b000;
        @(negedge clk);
        total++; if (owner !== 2'd1) begin bad++; $display("FAIL wait_owner: got %0d want 1", owner); end
        total++; if (digit_code !== exp_code(16'h2222)) begin bad++; $display("FAIL wait_code: got %h want %h", digit_code, exp_code(16'h2222)); end
        repeat (10) @(negedge clk);
        total++; if (owner !== 2'd3) begin bad++; $display("FAIL wait_drain: got %0d want 3", owner); end
    endtask

    task automatic test_reset_mid_show();
        @(posedge clk); #1 req = 3'b001; req_data = {32'h0, 16'hABCD};
        @(posedge clk); #1 req = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; req = 3'b010;
        #1;
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL rst_mid_an: got %b want 1110", an); end
        total++; if (owner !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_owner: got owner=%0d busy=%b want 3/0", owner, busy); end
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL rst_mid_ack: got %b want 000", ack); end
        total++; if (digit_code !== 4'h4) begin bad++; $display("FAIL rst_mid_code: got %h want 4", digit_code); end
        @(posedge clk); #1 reset = 1'b0; req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (an !== an_tab[i/4] || digit_code !== idle_tab[i/4]) begin bad++; $display("FAIL rst_rescan[%0d]: got an=%b code=%h want %b/%h", i, an, digit_code, an_tab[i/4], idle_tab[i/4]); end
        end
        @(posedge clk); #1 req = 3'b001; req_data = {32'h0, 16'h5A5A};
        @(negedge clk);
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL rst_regrant_ack: got %b want 001", ack); end
        @(posedge clk); #1 req = 3'b000;
        @(negedge clk);
        total++; if (owner !== 2'd0 || digit_code !== exp_code(16'h5A5A)) begin bad++; $display("FAIL rst_regrant: got owner=%0d code=%h want 0/%h", owner, digit_code, exp_code(16'h5A5A)); end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rx();
        test_priority();
        test_preempt();
        test_wait();
        test_reset_mid_show();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the single 4-digit 7-segment display between three message requesters: RX byte, TX byte and error/status. It also falls back to a live idle message when no requester holds the display. It grants one requester at a time by fixed priority, latches that requester's 16-bit message and holds it for a minimum time. It also owns the digit multiplex scan, driving the anodes and the 4-bit code of the active digit to the downstream segment decoder.

Parameters:
REFRESH_CYCLES, 200_000, clk cycles per digit slot in the scan (digit index advances on wrap)
HOLD_CYCLES, 100_000_000, clk cycles a granted message stays on the display (1 s at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  3  display request per requester; req[2]=error (highest priority), req[1]=TX, req[0]=RX (lowest)
req_data  input  48  messages; requester i owns bits [16i+15:16i]; nibble k = digit k (k=0 rightmost)
idle_msg  input  16  message shown while idle; sampled live, not latched
ack  output  3  one-cycle pulse to the requester whose message was latched this cycle
owner  output  2  current display owner: 0/1/2 = requester index, 3 = idle
busy  output  1  high while in SHOW
an  output  4  active-low digit enables; exactly one bit low at all times
digit_code  output  4  nibble for the digit currently enabled

Behaviour:
- Reset (async, asserted): state=IDLE, owner=3, ack=000, hold_cnt=0, refresh_cnt=0, digit_idx=0, latched msg=0. While in reset: an=4'b1110, digit_code=idle_msg[3:0].
- Reset mid-SHOW aborts the message immediately and issues no ack.
- States: IDLE and SHOW.
- IDLE: displayed word = idle_msg. If any req bit is high, grant the highest set index g:
  - latch req_data[16g+15:16g];
  - pulse ack[g] in the same cycle;
  - on the next edge: owner=g, state=SHOW, hold_cnt=0.
- SHOW: displayed word = latched msg; hold_cnt increments each cycle.
  - Expiry: when hold_cnt==HOLD_CYCLES-1 and no grantable request is present, go to IDLE on the next edge with owner=3.
- Grantable during SHOW: the highest set req index g with g >= owner. A request at the same priority as the owner re-latches the message.
  - The grant re-latches the message, pulses ack[g], sets owner=g and restarts hold_cnt=0, so preemption is immediate.
  - Requests with g < owner wait; they are not acked.
- Simultaneous hold expiry and pending lower request: the lower request is granted in that cycle and the state stays SHOW, with no IDLE cycle in between.
- Requesters hold req high until they see ack. ack is never high for more than one cycle per grant, and at most one ack bit is high.
- Scan:
  - refresh_cnt counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, digit_idx increments mod 4 (3 wraps to 0).
  - The scan runs independently of the arbiter state and is never reset by a grant.
- an = ~(4'b0001 << digit_idx). digit_code = displayed_word[4*digit_idx+3 : 4*digit_idx]. Both are combinational from registers, so a new message appears at the next clk edge after the grant.
- Counter widths: refresh_cnt uses $clog2(REFRESH_CYCLES) bits and hold_cnt uses $clog2(HOLD_CYCLES) bits; neither may overflow past its terminal value.

Decomposition:
- Shared package: state enum (IDLE, SHOW), OWNER_IDLE=2'd3, requester index constants REQ_RX=0, REQ_TX=1, REQ_ERR=2, NUM_DIGITS=4.
- Sub-module digit_scanner (parameter REFRESH_CYCLES; ports clk, reset, digit_idx[1:0]) holds the refresh counter and digit index.
- Arbitration, latching and hold timing stay in the top module.

Test Plan:
(Bench overrides: REFRESH_CYCLES=4, HOLD_CYCLES=10.)
- Reset then idle_msg=16'h1234, no req:
  - an cycles 1110→1101→1011→0111 every 4 clks;
  - digit_code follows 4,3,2,1;
  - owner=3, busy=0.
- req[0] with data 16'hABCD:
  - ack=001 for exactly one cycle;
  - digit_code shows D,C,B,A for 10 clks;
  - then returns to idle_msg with owner=3.
- req[0] and req[2] raised in the same cycle (data0=16'h1111, data2=16'hEEEE):
  - ack=100, owner=2, display EEEE;
  - req[0] stays pending;
  - when hold expires, ack=001 and the display switches to 1111 with no IDLE cycle.
- While owner=0 at hold_cnt=5, assert req[1] (16'h2222):
  - preempts on that cycle: ack=010, owner=1;
  - hold restarts and runs a full 10 clks.
- While owner=2, assert req[1]:
  - no ack until owner=2 expires, then ack=010.
- Assert reset mid-SHOW:
  - an=1110, owner=3, ack=000 immediately;
  - after release, the block behaves as after power-on.
